offset_div_ctrl: RTL and testbench

Sequencing controller for the offset divider's register banks. It drives the parallel-load and shift enables of the remainder/quotient flop banks through a restoring shift-subtract division, one quotient bit per two cycles. It takes a start/done handshake from the quantizer pipeline and a compare flag from the divider's subtractor, and flags divide-by-zero. The controller holds no data; it issues enables only.

---
 rtl/offset_div_pkg.sv | 18 +
 rtl/offset_div_step_counter.sv | 32 +++
 rtl/offset_div_ctrl.sv | 96 +++++++++
 tb/tb_offset_div_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/offset_div_pkg.sv
// Shared definitions for the offset divider sequencing controller:
// state encoding and the step-counter width helper.
package offset_div_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] S_LOAD  = 3'd1;
   localparam logic [STATE_W-1:0] S_SHIFT = 3'd2;
   localparam logic [STATE_W-1:0] S_TEST  = 3'd3;
   localparam logic [STATE_W-1:0] S_DONE  = 3'd4;

   // Counter must hold WIDTH-1; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/offset_div_step_counter.sv
// Loadable down-counter tracking the remaining quotient bits; is_zero marks
// the final TEST step.
module offset_div_step_counter
   import offset_div_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic is_zero
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LOAD_VAL = CW'(WIDTH - 1);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= LOAD_VAL;
      end else if (dec) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign is_zero = (cnt_reg == '0);

endmodule

// File: rtl/offset_div_ctrl.sv
// Sequencing controller for a restoring shift-subtract divider: issues bank
// enables only, one quotient bit per SHIFT/TEST pair.
module offset_div_ctrl
   import offset_div_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic divisor_zero,
   input  logic sub_ok,
   output logic load_en,
   output logic shift_en,
   output logic rem_load,
   output logic q_set,
   output logic busy,
   output logic done,
   output logic div_by_zero
);

   logic [STATE_W-1:0] state_reg;
   logic [STATE_W-1:0] state_next;
   logic               dbz_reg;
   logic               cnt_zero;
   logic               cnt_load;
   logic               cnt_dec;

   assign cnt_load = (state_reg == S_LOAD) && !divisor_zero;
   assign cnt_dec  = (state_reg == S_TEST) && !cnt_zero;

   offset_div_step_counter #(.WIDTH(WIDTH)) u_step_counter (
      .clk     (clk),
      .rst     (rst),
      .load    (cnt_load),
      .dec     (cnt_dec),
      .is_zero (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         dbz_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_LOAD) begin
            dbz_reg <= divisor_zero;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  state_next = start ? S_LOAD : S_IDLE;
         S_LOAD:  state_next = divisor_zero ? S_DONE : S_SHIFT;
         S_SHIFT: state_next = S_TEST;
         S_TEST:  state_next = cnt_zero ? S_DONE : S_SHIFT;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // rem_load/q_set are the only Mealy outputs: the subtract result is
   // committed in the same TEST cycle the compare resolves.
   always_comb begin
      load_en     = 1'b0;
      shift_en    = 1'b0;
      rem_load    = 1'b0;
      q_set       = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      div_by_zero = 1'b0;
      case (state_reg)
         S_LOAD: begin
            load_en = 1'b1;
            busy    = 1'b1;
         end
         S_SHIFT: begin
            shift_en = 1'b1;
            busy     = 1'b1;
         end
         S_TEST: begin
            busy     = 1'b1;
            rem_load = sub_ok;
            q_set    = sub_ok;
         end
         S_DONE: begin
            done        = 1'b1;
            div_by_zero = dbz_reg;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_offset_div_ctrl.sv
// Bench for offset_div_ctrl: a flop-bank datapath model driven by the DUT's
// enables, checked against plain arithmetic division and cycle expectations.
module tb_offset_div_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic divisor_zero;
   logic sub_ok;
   logic load_en, shift_en, rem_load, q_set, busy, done, div_by_zero;

   logic [W-1:0] dividend_r = '0;
   logic [W-1:0] divisor_r  = 8'd1;
   logic [W:0]   rem_bank   = '0;
   logic [W-1:0] quo_bank   = '0;
   bit           mon_en     = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   offset_div_ctrl #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .divisor_zero (divisor_zero),
      .sub_ok       (sub_ok),
      .load_en      (load_en),
      .shift_en     (shift_en),
      .rem_load     (rem_load),
      .q_set        (q_set),
      .busy         (busy),
      .done         (done),
      .div_by_zero  (div_by_zero)
   );

   // Datapath banks: remainder is one bit wider so the post-shift value
   // never overflows before the compare.
   assign divisor_zero = (divisor_r == '0);
   assign sub_ok       = (rem_bank >= {1'b0, divisor_r});

   always @(posedge clk) begin
      if (load_en) begin
         quo_bank <= dividend_r;
         rem_bank <= '0;
      end else if (shift_en) begin
         {rem_bank, quo_bank} <= {rem_bank[W-1:0], quo_bank, 1'b0};
      end
      if (rem_load) rem_bank <= rem_bank - {1'b0, divisor_r};
      if (q_set)    quo_bank[0] <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check("excl", 32'($countones({load_en, shift_en, rem_load}) <= 1), 32'd1);
         check("qset_eq", 32'(q_set), 32'(rem_load));
      end
   end

   // One division from start; optional stray start pulses in cycles 5 and 17.
   task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
      int done_cyc, ndone, shifts;
      logic [W-1:0] qv;
      bit prev_sh, dbz;
      @(negedge clk);
      dividend_r = a;
      divisor_r  = b;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      done_cyc = -1; ndone = 0; shifts = 0; qv = '0; prev_sh = 1'b0; dbz = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = poke && (c == 5 || c == 17);
         if (prev_sh) qv = {qv[W-2:0], q_set};
         prev_sh = shift_en;
         if (shift_en) shifts++;
         if (done) begin
            ndone++;
            if (done_cyc < 0) begin
               done_cyc = c;
               dbz = div_by_zero;
            end
         end
         if (done_cyc > 0 && c >= done_cyc + 3) break;
      end
      start = 1'b0;
      $display("div %0d/%0d: q=%0d r=%0d done@%0d dbz=%0d", a, b, quo_bank, rem_bank, done_cyc, dbz);
      check("done_cyc", 32'(done_cyc), (b == 0) ? 32'd2 : 32'(2 * W + 2));
      check("ndone", 32'(ndone), 32'd1);
      check("dbz", 32'(dbz), 32'(b == 0));
      if (b == 0) begin
         check("shifts_zero", 32'(shifts), 32'd0);
      end else begin
         check("quotient", 32'(quo_bank), 32'(a / b));
         check("remainder", 32'(rem_bank), 32'(a % b));
         check("qset_bits", 32'(qv), 32'(a / b));
         check("shifts", 32'(shifts), 32'(W));
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;
      check("reset_outs", 32'({load_en, shift_en, rem_load, q_set, busy, done, div_by_zero}), 32'd0);

      // Reference case: 100/7 has quotient bits set at steps 4,5,6.
      do_div(8'd100, 8'd7, 1'b0);
      do_div(8'd42, 8'd0, 1'b0);
      do_div(8'd200, 8'd13, 1'b1);

      // Reset in the middle of a run, then a fresh division.
      @(negedge clk);
      dividend_r = 8'd200;
      divisor_r  = 8'd3;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (c == 9) rst = 1'b1;
         if (c == 10) begin
            check("rst_outs_c10", 32'({load_en, shift_en, rem_load, q_set, busy, done, div_by_zero}), 32'd0);
            rst = 1'b0;
         end
         if (c == 11) check("rst_outs_c11", 32'({load_en, shift_en, rem_load, q_set, busy, done, div_by_zero}), 32'd0);
      end
      $display("reset mid-run applied");
      do_div(8'd255, 8'd1, 1'b0);

      for (int i = 0; i < 8; i++) begin
         logic [W-1:0] a, b;
         a = W'($urandom_range(0, 255));
         b = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 255));
         do_div(a, b, 1'b0);
      end

      // start held high: runs restart every 2*W+3 cycles.
      @(negedge clk);
      dividend_r = W'($urandom_range(0, 255));
      divisor_r  = W'($urandom_range(1, 255));
      start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 56; c++) begin
         int off;
         @(negedge clk);
         off = (c - 1) % (2 * W + 3);
         check("held_busy", 32'(busy), 32'(off <= 2 * W));
         check("held_done", 32'(done), 32'(off == 2 * W + 1));
         if (done) $display("held-start done at cycle %0d q=%0d r=%0d", c, quo_bank, rem_bank);
         if (c == 56) start = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("idle_after", 32'({busy, done}), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
